cpu_debug_dump: RTL and testbench

//  Debug/performance unit inside CPU. Counts elapsed cycles and retired instructions.
//  On request, walks the register file through a spare read port and streams every

---
 rtl/cpu_debug_dump_pkg.sv | 25 ++
 rtl/cpu_debug_dump_if.sv | 28 ++
 rtl/cpu_debug_dump_sat_counter.sv | 20 ++
 rtl/cpu_debug_dump.sv | 137 +++++++++++++
 tb/tb_cpu_debug_dump.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_debug_dump_pkg.sv
// Shared constants and FSM encoding for the debug dump unit.
package cpu_debug_dump_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned TAG_W    = 6;

  // Tags after the register words: cycle snapshot, then instruction snapshot.
  localparam logic [TAG_W-1:0] TAG_CYC   = TAG_W'(NUM_REGS);
  localparam logic [TAG_W-1:0] TAG_INSTR = TAG_W'(NUM_REGS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_CYC,
    ST_INSTR
  } state_t;

  // Tag carried by a register word is simply its index.
  function automatic logic [TAG_W-1:0] reg_tag(input logic [IDX_W-1:0] idx);
    return TAG_W'(idx);
  endfunction

endpackage

// File: rtl/cpu_debug_dump_if.sv
// Valid/ready word stream carrying dumped registers and counter snapshots.
interface cpu_debug_dump_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic                                  out_valid;
  logic                                  out_ready;
  logic [DATA_W-1:0]                     out_data;
  logic [cpu_debug_dump_pkg::TAG_W-1:0]  out_tag;
  logic                                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_tag,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_tag,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/cpu_debug_dump_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count enabled increments, holding once all-ones is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_debug_dump.sv
// Debug/performance unit: live cycle and retired-instruction counters, plus an
// on-demand dump of the register file and counter snapshots over a word stream.
module cpu_debug_dump
  import cpu_debug_dump_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_retire,
  input  logic              dump_req,
  output logic [IDX_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  cpu_debug_dump_if.master  dbg,
  output logic              busy,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cyc_snap, ins_snap;

  logic hs;
  logic snap, load_reg, next_reg, load_cyc, load_ins, finish;

  sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .count (cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ins_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_retire),
    .count (instr_cnt)
  );

  assign hs       = dbg.out_valid && dbg.out_ready;
  assign busy     = (state != ST_IDLE);
  assign rf_raddr = idx;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; emits one-hot datapath strobes for the register block.
  always_comb begin
    state_nxt = state;
    snap      = 1'b0;
    load_reg  = 1'b0;
    next_reg  = 1'b0;
    load_cyc  = 1'b0;
    load_ins  = 1'b0;
    finish    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (dump_req) begin
          snap      = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        load_reg  = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (hs) begin
          if (idx == IDX_W'(NUM_REGS - 1)) begin
            load_cyc  = 1'b1;
            state_nxt = ST_CYC;
          end else begin
            next_reg  = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_CYC: begin
        if (hs) begin
          load_ins  = 1'b1;
          state_nxt = ST_INSTR;
        end
      end
      ST_INSTR: begin
        if (hs) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Snapshots, walk index and the registered output word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx           <= '0;
      cyc_snap      <= '0;
      ins_snap      <= '0;
      dbg.out_valid <= 1'b0;
      dbg.out_data  <= '0;
      dbg.out_tag   <= '0;
      dbg.out_last  <= 1'b0;
    end else if (snap) begin
      // Counters still show the pre-increment value at this edge.
      idx      <= '0;
      cyc_snap <= cycle_cnt;
      ins_snap <= instr_cnt;
    end else if (load_reg) begin
      dbg.out_data  <= rf_rdata;
      dbg.out_tag   <= reg_tag(idx);
      dbg.out_valid <= 1'b1;
    end else if (next_reg) begin
      idx           <= idx + IDX_W'(1);
      dbg.out_valid <= 1'b0;
    end else if (load_cyc) begin
      dbg.out_data <= DATA_W'(cyc_snap);
      dbg.out_tag  <= TAG_CYC;
    end else if (load_ins) begin
      dbg.out_data <= DATA_W'(ins_snap);
      dbg.out_tag  <= TAG_INSTR;
      dbg.out_last <= 1'b1;
    end else if (finish) begin
      dbg.out_valid <= 1'b0;
      dbg.out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_debug_dump.sv
// Randomised bench for cpu_debug_dump with a queue-based reference model.
module tb_cpu_debug_dump;
  import cpu_debug_dump_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, instr_retire, dump_req;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        busy;
  logic [31:0] cycle_cnt, instr_cnt;
  logic [31:0] rf [32];

  assign rf_rdata = rf[rf_raddr];

  cpu_debug_dump_if #(.DATA_W(32)) dbg ();

  cpu_debug_dump #(.DATA_W(32), .CNT_W(32)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .instr_retire (instr_retire),
    .dump_req     (dump_req),
    .rf_raddr     (rf_raddr),
    .rf_rdata     (rf_rdata),
    .dbg          (dbg),
    .busy         (busy),
    .cycle_cnt    (cycle_cnt),
    .instr_cnt    (instr_cnt)
  );

  // Narrow-counter instance to reach saturation quickly.
  logic        retire_s;
  logic [4:0]  raddr_s;
  logic [31:0] rdata_s;
  logic        busy_s;
  logic [1:0]  cyc_s, ins_s;
  cpu_debug_dump_if #(.DATA_W(32)) dbg_s ();
  assign rdata_s = {27'd0, raddr_s};

  cpu_debug_dump #(.DATA_W(32), .CNT_W(2)) u_sat (
    .clk          (clk),
    .rst          (rst),
    .instr_retire (retire_s),
    .dump_req     (1'b0),
    .rf_raddr     (raddr_s),
    .rf_rdata     (rdata_s),
    .dbg          (dbg_s),
    .busy         (busy_s),
    .cycle_cnt    (cyc_s),
    .instr_cnt    (ins_s)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  tag;
    logic        last;
  } word_t;

  // Reference model: a dump is the queue of words implied by the register
  // file and counters at the accepting edge, released under the pacing rules.
  word_t       mq[$];
  word_t       mcur;
  logic        mvalid, mbusy, mdelay;
  logic [31:0] mcyc, mins;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      mcur = '0; mvalid = 1'b0; mbusy = 1'b0; mdelay = 1'b0;
      mcyc = '0; mins = '0;
    end else begin
      if (mvalid && dbg.out_ready) begin
        if (mq.size() == 0) begin
          mvalid = 1'b0; mbusy = 1'b0;
        end else if (mcur.tag < 6'd32 && mq[0].tag < 6'd32) begin
          mvalid = 1'b0; mdelay = 1'b1;
        end else begin
          mcur = mq.pop_front();
        end
      end else if (mdelay) begin
        mcur = mq.pop_front(); mvalid = 1'b1; mdelay = 1'b0;
      end else if (!mbusy && dump_req) begin
        for (int i = 0; i < 32; i++) mq.push_back('{data: rf[i], tag: 6'(i), last: 1'b0});
        mq.push_back('{data: mcyc, tag: 6'd32, last: 1'b0});
        mq.push_back('{data: mins, tag: 6'd33, last: 1'b1});
        mbusy = 1'b1; mdelay = 1'b1;
      end
      if (mcyc != '1) mcyc++;
      if (instr_retire && mins != '1) mins++;
    end
  end

  // Compare against the model and record accepted words, away from the active edge.
  word_t rec[$];
  always @(negedge clk) begin
    if (rst) begin
      chk("busy", {63'd0, busy}, {63'd0, mbusy});
      chk("cycle_cnt", {32'd0, cycle_cnt}, {32'd0, mcyc});
      chk("instr_cnt", {32'd0, instr_cnt}, {32'd0, mins});
      chk("out_valid", {63'd0, dbg.out_valid}, {63'd0, mvalid});
      if (mvalid) begin
        chk("out_data", {32'd0, dbg.out_data}, {32'd0, mcur.data});
        chk("out_tag", {58'd0, dbg.out_tag}, {58'd0, mcur.tag});
        chk("out_last", {63'd0, dbg.out_last}, {63'd0, mcur.last});
      end
      if (dbg.out_valid && dbg.out_ready)
        rec.push_back('{data: dbg.out_data, tag: dbg.out_tag, last: dbg.out_last});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk("dump_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic start_dump();
    rec.delete();
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
  endtask

  task automatic wait_tag(input logic [5:0] t);
    int n = 0;
    while (!(dbg.out_valid && dbg.out_tag == t) && n < 300) begin
      step();
      n++;
    end
    chk("reach_tag", {58'd0, dbg.out_tag}, {58'd0, t});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic [9:0] pat;
    pat = 10'b0010001101;
    rst = 1'b0; instr_retire = 1'b0; dump_req = 1'b0; retire_s = 1'b1;
    dbg.out_ready = 1'b1;
    dbg_s.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    repeat (3) step();
    chk("rst_valid", {63'd0, dbg.out_valid}, 64'd0);
    chk("rst_cycle", {32'd0, cycle_cnt}, 64'd0);
    rst = 1'b1;

    // Idle counting; narrow instance saturates meanwhile.
    for (int i = 0; i < 10; i++) begin
      instr_retire = pat[i];
      step();
      if (i == 1) chk("sat_ins_pre", {62'd0, ins_s}, 64'd2);
    end
    instr_retire = 1'b0;
    chk("idle_cycles", {32'd0, cycle_cnt}, 64'd10);
    chk("idle_instrs", {32'd0, instr_cnt}, 64'd4);
    chk("sat_ins", {62'd0, ins_s}, 64'd3);
    chk("sat_cyc", {62'd0, cyc_s}, 64'd3);
    chk("sat_idle", {32'd0, dbg_s.out_data, dbg_s.out_tag, dbg_s.out_last, busy_s, dbg_s.out_valid}, 64'd0);

    // Full dump, consumer always ready.
    start_dump();
    wait_idle(200, n);
    chk("dump_cycles", 64'(n), 64'd66);
    chk("dump_words", 64'(rec.size()), 64'd34);
    for (int i = 0; i < 34; i++) begin
      chk("w_tag", {58'd0, rec[i].tag}, 64'(i));
      chk("w_last", {63'd0, rec[i].last}, {63'd0, (i == 33)});
      if (i < 32) chk("w_reg", {32'd0, rec[i].data}, 64'h1000 + 64'(i));
    end
    chk("snap_cyc", {32'd0, rec[32].data}, 64'd10);
    chk("snap_ins", {32'd0, rec[33].data}, 64'd4);

    // Stall on tag 7 while the register is rewritten; re-request mid-dump.
    start_dump();
    wait_tag(6'd7);
    dbg.out_ready = 1'b0;
    rf[7] = 32'hDEAD;
    repeat (5) begin
      step();
      chk("stall_data", {32'd0, dbg.out_data}, 64'h1007);
      chk("stall_valid", {63'd0, dbg.out_valid}, 64'd1);
    end
    dbg.out_ready = 1'b1;
    n = 0;
    while (rec.size() < 10 && n < 100) begin step(); n++; end
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    wait_idle(200, n);
    repeat (3) step();
    chk("reissue_words", 64'(rec.size()), 64'd34);
    chk("reissue_tag7", {32'd0, rec[7].data}, 64'h1007);
    chk("reissue_idle", {63'd0, busy}, 64'd0);
    rf[7] = 32'h1007;

    // Randomised dumps with backpressure, retires, writes and spurious requests.
    for (int d = 0; d < 6; d++) begin
      start_dump();
      n = 0;
      while (busy && n < 2000) begin
        dbg.out_ready = ($urandom_range(0, 3) != 0);
        instr_retire  = 1'($urandom_range(0, 1));
        dump_req      = ($urandom_range(0, 7) == 0);
        if (dbg.out_valid && dbg.out_tag < 6'd32 && $urandom_range(0, 3) == 0)
          rf[$urandom_range(0, int'(dbg.out_tag))] = $urandom;
        step();
        n++;
      end
      dump_req = 1'b0; instr_retire = 1'b0; dbg.out_ready = 1'b1;
      chk("rand_done", {63'd0, busy}, 64'd0);
      chk("rand_words", 64'(rec.size()), 64'd34);
      repeat ($urandom_range(0, 3)) step();
    end

    // Asynchronous reset in the middle of a dump.
    start_dump();
    wait_tag(6'd15);
    rst = 1'b0;
    #1;
    chk("arst_valid", {63'd0, dbg.out_valid}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_cycle", {32'd0, cycle_cnt}, 64'd0);
    chk("arst_instr", {32'd0, instr_cnt}, 64'd0);
    chk("arst_word", {26'd0, dbg.out_data, dbg.out_tag}, 64'd0);
    chk("arst_last", {63'd0, dbg.out_last}, 64'd0);
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("post_rst_valid", {63'd0, dbg.out_valid}, 64'd0);
    chk("post_rst_cycle", {32'd0, cycle_cnt}, 64'd1);
    start_dump();
    wait_idle(200, n);
    chk("post_rst_words", 64'(rec.size()), 64'd34);
    chk("post_rst_first", {58'd0, rec[0].tag}, 64'd0);
    chk("post_rst_snap", {32'd0, rec[32].data}, 64'd1);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
